rx_data_buffer: RTL and testbench
=================================

RX_DATA_BUFFER -- requirements
Module: rx_data_buffer

Parameters
REQ-001 The block SHALL have parameter WORD_LENGTH, default 8: data bits per frame.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of FIFO entries; only powers of two from 2 to 16 are legal.
REQ-003 The block SHALL have parameter CW, default 3: FIFO count width, equal to log2(DEPTH)+1.

Interface
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 SerialDataIn  input  1  serial RX line, already synchronized, shared with the RX FSM.
REQ-007 shift_RX  input  1  one-cycle pulse from the RX FSM; sample one data bit now.
REQ-008 ready  input  1  one-cycle pulse from the RX FSM; frame ended and the line is at the stop-bit sample.
REQ-009 rd_en  input  1  consumer pops the head word.
REQ-010 err_clr  input  1  clears the sticky error flags.
REQ-011 rx_data  output  WORD_LENGTH  FIFO head word, first-word-fall-through.
REQ-012 rx_valid  output  1  FIFO is not empty; rx_data is valid.
REQ-013 fifo_full  output  1  FIFO holds DEPTH words.
REQ-014 fifo_count  output  CW  number of stored words.
REQ-015 framing_err  output  1  sticky flag: bad stop bit or wrong bit count.
REQ-016 overrun_err  output  1  sticky flag: a good word was dropped because the FIFO was full.

Function
REQ-017 On a shift_RX pulse, the shift register SHALL load LSB first: sr <= {SerialDataIn, sr[WORD_LENGTH-1:1]}.
REQ-018 Each shift_RX pulse SHALL increment bit_cnt; bit_cnt SHALL saturate at WORD_LENGTH+1 and SHALL NOT wrap.
REQ-019 On a ready pulse, a frame SHALL be classed good when bit_cnt==WORD_LENGTH and SerialDataIn==1; otherwise it SHALL be classed bad.
REQ-020 A good frame SHALL be pushed into the FIFO in the cycle after ready, with sr captured at the ready edge.
REQ-021 A bad frame SHALL set framing_err and SHALL NOT be pushed.
REQ-022 Every ready pulse SHALL clear bit_cnt to 0, whether the frame is good or bad.
REQ-023 If shift_RX and ready arrive in the same cycle, ready SHALL win; the shift SHALL be ignored and bit_cnt SHALL still clear.
REQ-024 rd_en with rx_valid==1 SHALL advance the head pointer, and the next word SHALL appear on rx_data the following cycle.
REQ-025 rd_en with rx_valid==0 SHALL be ignored, with no pointer or count change.
REQ-026 A push while full with no simultaneous pop SHALL drop the word, set overrun_err, and leave FIFO contents unchanged.
REQ-027 A push and a pop in the same cycle while full SHALL both succeed; fifo_count SHALL stay DEPTH and no overrun SHALL occur.
REQ-028 A push and a pop in the same cycle while empty SHALL apply the push only; the pop is ignored and fifo_count becomes 1.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 fifo_full SHALL equal (fifo_count==DEPTH), and rx_valid SHALL equal (fifo_count!=0).
REQ-031 err_clr SHALL clear both sticky flags on the next edge; if an error event occurs in the same cycle, the set SHALL win.
REQ-032 Push latency SHALL be 2 cycles from the ready pulse to rx_valid rising on an empty FIFO.

Reset
REQ-033 Asserting reset SHALL immediately clear sr, bit_cnt, both pointers, fifo_count, framing_err, overrun_err, rx_valid and fifo_full.
REQ-034 rx_data SHALL read 0 during reset and whenever the FIFO is empty.
REQ-035 Reset mid-frame SHALL discard the partial frame; the first ready pulse after reset release with bit_cnt 0 SHALL be treated as bad.
REQ-036 The FIFO storage array SHALL NOT require a reset.

Verification
REQ-037 Send 8 shift_RX pulses with bits 1,0,1,0,0,1,0,1, then ready with line=1 -> rx_data=8'hA5, rx_valid=1 two cycles after ready, fifo_count=1.
REQ-038 Send 8 shifts of 0x3C, then ready with line=0 -> framing_err=1, fifo_count unchanged; err_clr -> framing_err=0 next cycle.
REQ-039 Send only 7 shifts, then ready with line=1 -> framing_err=1, no push; the next full 0x55 frame pushes 0x55.
REQ-040 Push 5 good frames 0x01 to 0x05 with no reads (DEPTH=4) -> fifo_full=1, overrun_err=1; reads return 0x01 to 0x04 in order.
REQ-041 With the FIFO full, a push and rd_en in the same cycle -> fifo_count stays 4, overrun_err stays 0, and the oldest word is popped.
REQ-042 Assert reset after 4 shifts, release, then send a full 0x81 frame -> rx_data=0x81, framing_err=0, fifo_count=1.

Source files
------------

// File: rtl/rx_data_buffer.sv
// rx_data_buffer: receive-side data path for a UART-style RX FSM.
// Bits are shifted in LSB first on shift_RX pulses. A ready pulse ends the
// frame and decides whether the word is good, using the bit count and the
// stop-bit level. Good words go into a first-word-fall-through FIFO, and
// errors are kept in sticky flags.
module rx_data_buffer #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 4,
    parameter int CW          = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   SerialDataIn,
    input  logic                   shift_RX,
    input  logic                   ready,
    input  logic                   rd_en,
    input  logic                   err_clr,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   fifo_full,
    output logic [CW-1:0]          fifo_count,
    output logic                   framing_err,
    output logic                   overrun_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(WORD_LENGTH + 2);
    localparam logic [BW-1:0] BIT_SAT   = BW'(WORD_LENGTH + 1);
    localparam logic [BW-1:0] BIT_FULL  = BW'(WORD_LENGTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    // Shift register and frame bookkeeping
    logic [WORD_LENGTH-1:0] sr_q;
    logic [BW-1:0]          bit_cnt_q;
    logic                   push_q;       // good word waiting to enter the FIFO
    logic [WORD_LENGTH-1:0] push_data_q;  // value of sr at the ready edge

    // FIFO state
    logic [WORD_LENGTH-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   framing_q, framing_d;
    logic                   overrun_q, overrun_d;

    logic frame_good;
    logic pop;
    logic is_full;
    logic wr_ok;
    logic overrun_evt;
    logic framing_evt;

    assign frame_good  = (bit_cnt_q == BIT_FULL) && SerialDataIn;
    assign framing_evt = ready && !frame_good;
    assign is_full     = (count_q == DEPTH_CNT);
    assign pop         = rd_en && (count_q != '0);
    // When the FIFO is full, a push can only go in if a pop frees a slot in the same cycle.
    assign wr_ok       = push_q && (!is_full || pop);
    assign overrun_evt = push_q && is_full && !pop;

    // Shift in data bits and classify the frame; ready takes priority over shift_RX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else if (ready) begin
            bit_cnt_q   <= '0;
            push_q      <= frame_good;
            push_data_q <= sr_q;
        end else begin
            push_q <= 1'b0;
            if (shift_RX) begin
                sr_q <= {SerialDataIn, sr_q[WORD_LENGTH-1:1]};
                if (bit_cnt_q != BIT_SAT) begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
        end
    end

    // Next-state logic for the FIFO pointers, the count and the sticky flags
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        framing_d = err_clr ? 1'b0 : framing_q;
        overrun_d = err_clr ? 1'b0 : overrun_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // An error in the same cycle as err_clr still sets the flag.
        if (framing_evt) begin
            framing_d = 1'b1;
        end
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            framing_q <= framing_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array; no reset because rx_data is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= push_data_q;
        end
    end

    assign rx_valid    = (count_q != '0);
    assign fifo_full   = is_full;
    assign fifo_count  = count_q;
    assign rx_data     = rx_valid ? mem[rd_ptr_q] : '0;
    assign framing_err = framing_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_rx_data_buffer.sv
// Directed bench for rx_data_buffer. Inputs are driven and outputs sampled
// on the falling clock edge.
`timescale 1ns/1ps
module tb_rx_data_buffer;

    logic       clk;
    logic       reset;
    logic       SerialDataIn;
    logic       shift_RX;
    logic       ready;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       framing_err;
    logic       overrun_err;

    int total = 0;
    int bad   = 0;

    rx_data_buffer #(.WORD_LENGTH(8), .DEPTH(4), .CW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .SerialDataIn (SerialDataIn),
        .shift_RX     (shift_RX),
        .ready        (ready),
        .rd_en        (rd_en),
        .err_clr      (err_clr),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .framing_err  (framing_err),
        .overrun_err  (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        SerialDataIn = b;
        shift_RX     = 1'b1;
        @(negedge clk);
        shift_RX     = 1'b0;
        SerialDataIn = 1'b1;
    endtask

    // Holds ready across one rising edge, then returns on the next falling edge.
    task automatic send_ready(input logic line);
        @(negedge clk);
        SerialDataIn = line;
        ready        = 1'b1;
        @(negedge clk);
        ready        = 1'b0;
        SerialDataIn = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(d, 8);
        send_ready(stop);
        @(negedge clk);
    endtask

    task automatic pop_one;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clear_errs;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] bits;
        reset = 1'b1; SerialDataIn = 1'b1; shift_RX = 1'b0; ready = 1'b0;
        rd_en = 1'b0; err_clr = 1'b0;
        idle(2);
        chk("rst_valid", rx_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_oerr", overrun_err, 0);
        reset = 1'b0;
        idle(1);

        // A5 frame, fed bit by bit, and the 2-cycle push latency
        bits = 8'b1010_0101;
        for (int i = 0; i < 8; i++) send_bit(bits[i]);
        send_ready(1'b1);
        chk("a5_valid_cyc1", rx_valid, 0);
        @(negedge clk);
        chk("a5_valid_cyc2", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_count", fifo_count, 1);
        chk("a5_ferr", framing_err, 0);
        pop_one();
        chk("a5_pop_count", fifo_count, 0);
        chk("a5_pop_data", rx_data, 0);
        // A read from an empty FIFO has no effect
        pop_one();
        chk("empty_pop_count", fifo_count, 0);
        chk("empty_pop_valid", rx_valid, 0);

        // A bad stop bit sets the framing error, and err_clr clears it
        send_bits(8'h3C, 8);
        send_ready(1'b0);
        chk("3c_ferr", framing_err, 1);
        @(negedge clk);
        chk("3c_count", fifo_count, 0);
        clear_errs();
        chk("3c_ferr_clr", framing_err, 0);

        // A short frame is bad; the next full frame is accepted
        send_bits(8'h55, 7);
        send_ready(1'b1);
        chk("short_ferr", framing_err, 1);
        @(negedge clk);
        chk("short_count", fifo_count, 0);
        send_frame(8'h55, 1'b1);
        chk("55_data", rx_data, 8'h55);
        chk("55_count", fifo_count, 1);
        clear_errs();
        pop_one();

        // Overrun: five pushes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        chk("ovr_full", fifo_full, 1);
        chk("ovr_count", fifo_count, 4);
        chk("ovr_oerr", overrun_err, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_rd%0d", i), rx_data, 32'(i));
            pop_one();
        end
        chk("ovr_empty", rx_valid, 0);
        clear_errs();
        chk("ovr_oerr_clr", overrun_err, 0);

        // A push and a pop in the same cycle while full
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        chk("pp_full", fifo_full, 1);
        send_bits(8'h14, 8);
        send_ready(1'b1);
        rd_en = 1'b1;              // pop lands on the same edge as the push
        @(negedge clk);
        rd_en = 1'b0;
        chk("pp_count", fifo_count, 4);
        chk("pp_oerr", overrun_err, 0);
        chk("pp_head", rx_data, 8'h11);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("pp_rd%0d", i), rx_data, 32'h10 + 32'(i));
            pop_one();
        end

        // shift_RX and ready together: ready wins and bit_cnt still clears
        send_bits(8'h42, 8);
        @(negedge clk);
        SerialDataIn = 1'b1; shift_RX = 1'b1; ready = 1'b1;
        @(negedge clk);
        shift_RX = 1'b0; ready = 1'b0;
        @(negedge clk);
        chk("coll_data", rx_data, 8'h42);
        chk("coll_ferr", framing_err, 0);
        send_frame(8'h24, 1'b1);
        chk("coll_next_count", fifo_count, 2);
        chk("coll_next_ferr", framing_err, 0);

        // Reset in the middle of a frame
        send_bits(8'hFF, 4);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_count", fifo_count, 0);
        chk("midrst_data", rx_data, 0);
        @(negedge clk);
        reset = 1'b0;
        send_frame(8'h81, 1'b1);
        chk("81_data", rx_data, 8'h81);
        chk("81_ferr", framing_err, 0);
        chk("81_count", fifo_count, 1);
        send_ready(1'b1);           // bit_cnt is 0, so this frame is bad
        chk("empty_ready_ferr", framing_err, 1);
        @(negedge clk);
        chk("empty_ready_count", fifo_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
